// File: rtl/axi4_burst_master_pkg.sv
// Shared encodings for the AXI4 burst master: FSM states, burst type, size and response codes.
package axi4_burst_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GRANT,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_RELEASE
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_BYTE   = 3'b000;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_beat_counter.sv
// Burst beat counter: clears on entry to the data phase, counts handshakes, flags the last beat.
module axi4_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic [7:0] len_i,
    output logic [7:0] cnt_o,
    output logic       last_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi4_burst_master.sv
// Single-burst AXI4 master: takes one command, wins the interconnect grant, runs one INCR burst,
// then reports completion with the slave response (or SLVERR for an out-of-range command).
module axi4_burst_master
    import axi4_burst_master_pkg::*;
#(
    parameter int         memWidth      = 8,
    parameter int         memDepth      = 32,
    parameter int         addressLength = 5,
    parameter logic [3:0] masterId      = 4'h1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [addressLength-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [memWidth-1:0]      wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [memWidth-1:0]      rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     done,
    output logic [1:0]               done_resp,
    input  logic                     Master_Set,
    output logic                     Master_Release,
    output logic [3:0]               ARID,
    output logic [addressLength-1:0] ARADDR,
    output logic [1:0]               ARBURST,
    output logic                     ARVALID,
    output logic [7:0]               ARLEN,
    output logic [2:0]               ARSIZE,
    input  logic                     ARREADY,
    input  logic [3:0]               RID,
    input  logic [memWidth-1:0]      RDATA,
    input  logic                     RLAST,
    input  logic                     RVALID,
    input  logic [1:0]               RRESP,
    output logic                     RREADY,
    output logic [3:0]               AWID,
    output logic [addressLength-1:0] AWADDR,
    output logic [1:0]               AWBURST,
    output logic                     AWVALID,
    output logic [7:0]               AWLEN,
    output logic [2:0]               AWSIZE,
    input  logic                     AWREADY,
    output logic [3:0]               WID,
    output logic [memWidth-1:0]      WDATA,
    output logic                     WLAST,
    output logic                     WVALID,
    input  logic                     WREADY,
    input  logic [3:0]               BID,
    input  logic [1:0]               BRESP,
    input  logic                     BVALID,
    output logic                     BREADY
);

    state_e                   state_q, state_d;
    logic                     write_q, write_d;
    logic [addressLength-1:0] addr_q, addr_d;
    logic [7:0]               len_q, len_d;
    logic                     done_q, done_d;
    logic [1:0]               done_resp_q, done_resp_d;

    logic       cnt_clr, cnt_inc, cnt_last;
    logic [7:0] cnt;
    logic [8:0] end_addr;
    logic       range_err;
    logic       unused_ids;

    assign end_addr   = 9'(cmd_addr) + 9'(cmd_len);
    assign range_err  = (end_addr > 9'(memDepth - 1));
    assign unused_ids = ^{RID, BID};

    axi4_beat_counter u_beat_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .len_i  (len_q),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        addr_d         = addr_q;
        len_d          = len_q;
        done_d         = 1'b0;
        done_resp_d    = done_resp_q;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        cmd_ready      = 1'b0;
        Master_Release = 1'b0;
        ARVALID        = 1'b0;
        AWVALID        = 1'b0;
        WVALID         = 1'b0;
        wr_ready       = 1'b0;
        rd_valid       = 1'b0;
        RREADY         = 1'b0;
        BREADY         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready      = 1'b1;
                Master_Release = 1'b1;
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    // Bursts running past the slave's top word never reach the bus.
                    if (range_err) begin
                        done_d      = 1'b1;
                        done_resp_d = RESP_SLVERR;
                    end else begin
                        state_d = ST_WAIT_GRANT;
                    end
                end
            end
            ST_WAIT_GRANT: begin
                if (Master_Set)
                    state_d = ST_ADDR;
            end
            ST_ADDR: begin
                ARVALID = !write_q;
                AWVALID = write_q;
                if (write_q ? AWREADY : ARREADY) begin
                    cnt_clr = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (write_q) begin
                    WVALID   = wr_valid;
                    wr_ready = WREADY;
                    cnt_inc  = wr_valid && WREADY;
                    if (wr_valid && WREADY && cnt_last)
                        state_d = ST_RESP;
                end else begin
                    rd_valid = RVALID;
                    RREADY   = rd_ready;
                    cnt_inc  = RVALID && rd_ready;
                    if (RVALID && rd_ready && (RLAST || cnt_last)) begin
                        done_d      = 1'b1;
                        done_resp_d = RRESP;
                        state_d     = ST_RELEASE;
                    end
                end
            end
            ST_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    done_d      = 1'b1;
                    done_resp_d = BRESP;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                Master_Release = 1'b1;
                if (!Master_Set)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // While reset is held the bus side looks idle and released regardless of state.
        if (rst) begin
            cmd_ready      = 1'b0;
            Master_Release = 1'b1;
            ARVALID        = 1'b0;
            AWVALID        = 1'b0;
            WVALID         = 1'b0;
            wr_ready       = 1'b0;
            rd_valid       = 1'b0;
            RREADY         = 1'b0;
            BREADY         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
        end
    end

    assign ARID      = masterId;
    assign AWID      = masterId;
    assign WID       = masterId;
    assign ARADDR    = addr_q;
    assign AWADDR    = addr_q;
    assign ARLEN     = len_q;
    assign AWLEN     = len_q;
    assign ARBURST   = BURST_INCR;
    assign AWBURST   = BURST_INCR;
    assign ARSIZE    = SIZE_BYTE;
    assign AWSIZE    = SIZE_BYTE;
    assign WDATA     = wr_data;
    assign WLAST     = (state_q == ST_DATA) && write_q && cnt_last && !rst;
    assign rd_data   = RDATA;
    assign done      = done_q;
    assign done_resp = done_resp_q;

endmodule
